// File: rtl/ah_pkt_pkg.sv
// Purpose : shared constants, FSM encoding and window map for the 96-bit/15-client encoder and decoder.
// Latency : n/a (types, constants and a pure function only).
// Backpressure : n/a.
package ah_pkt_pkg;

    localparam int NUM_CLIENTS = 15;
    localparam int FIELD_W     = 96;
    localparam int OFFSET_W    = 16;
    localparam int WINDOW_W    = 12;
    localparam int CLIENT_ID_W = 4;
    localparam int ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Base address of client idx's 4 KiB window. Arithmetic wraps modulo 2^32,
    // matching the decoder's view of the address map.
    function automatic logic [ADDR_W-1:0] window_base(
        input logic [CLIENT_ID_W-1:0] idx,
        input logic [ADDR_W-1:0]      base
    );
        return base + (ADDR_W'(idx) << WINDOW_W);
    endfunction

endpackage

// File: rtl/ah_rr_arbiter_15.sv
// Purpose : round-robin pick among 15 requesters, searching upward from ptr with wrap.
// Latency : purely combinational, zero cycles.
// Backpressure : none; the caller decides when the pick is consumed.
// Ports   : req (request vector), ptr (first index searched), onehot/winner (pick), any (some request set).
module ah_rr_arbiter_15
    import ah_pkt_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [CLIENT_ID_W-1:0] ptr,
    output logic [NUM_CLIENTS-1:0] onehot,
    output logic [CLIENT_ID_W-1:0] winner,
    output logic                   any
);

    logic [CLIENT_ID_W:0] idx;

    always_comb begin
        onehot = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            // ptr stays within 0..14, so one subtraction is enough to wrap.
            idx = {1'b0, ptr} + (CLIENT_ID_W+1)'(k);
            if (idx >= (CLIENT_ID_W+1)'(NUM_CLIENTS)) begin
                idx = idx - (CLIENT_ID_W+1)'(NUM_CLIENTS);
            end
            if (!any && req[idx[CLIENT_ID_W-1:0]]) begin
                any                         = 1'b1;
                winner                      = idx[CLIENT_ID_W-1:0];
                onehot[idx[CLIENT_ID_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ah_encoder_96_15.sv
// Purpose : arbitrate 15 clients and encode base+window+offset into a 96-bit egress field.
// Latency : request sampled at cycle T gives client_gnt and egress_valid at T+1; max 1 packet / 2 cycles.
// Backpressure : field held stable while egress_valid && !egress_ready; no arbitration until accepted.
// Ports   : clk/rst (sync, active-high); client_req/client_offset in, client_gnt out;
//           egress_pkt_field/egress_valid/egress_ready handshake; encoded_binary owner id; enc_err pulse.
module ah_encoder_96_15
    import ah_pkt_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CLIENTS-1:0]          client_req,
    input  logic [NUM_CLIENTS*OFFSET_W-1:0] client_offset,
    output logic [NUM_CLIENTS-1:0]          client_gnt,
    output logic [FIELD_W-1:0]              egress_pkt_field,
    output logic                            egress_valid,
    input  logic                            egress_ready,
    output logic [CLIENT_ID_W-1:0]          encoded_binary,
    output logic                            enc_err
);

    state_t                 state, state_nxt;
    logic [CLIENT_ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [NUM_CLIENTS-1:0] gnt_nxt;
    logic [FIELD_W-1:0]     field_nxt;
    logic [CLIENT_ID_W-1:0] bin_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;

    logic [NUM_CLIENTS-1:0] arb_onehot;
    logic [CLIENT_ID_W-1:0] arb_bin;
    logic                   arb_any;

    logic [OFFSET_W-1:0]    offsets [NUM_CLIENTS];
    logic [OFFSET_W-1:0]    off_sel;
    logic                   in_window;
    logic [ADDR_W-1:0]      enc_addr;

    ah_rr_arbiter_15 u_arb (
        .req    (client_req),
        .ptr    (rr_ptr),
        .onehot (arb_onehot),
        .winner (arb_bin),
        .any    (arb_any)
    );

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_off
        assign offsets[i] = client_offset[i*OFFSET_W +: OFFSET_W];
    end

    assign off_sel   = offsets[arb_bin];
    // Any bit at or above the window size puts the offset outside the window.
    assign in_window = (off_sel[OFFSET_W-1:WINDOW_W] == '0);
    assign enc_addr  = window_base(arb_bin, BASE_ADDR) + ADDR_W'(off_sel);

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        valid_nxt  = egress_valid;
        field_nxt  = egress_pkt_field;
        bin_nxt    = encoded_binary;
        gnt_nxt    = '0;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt_nxt    = arb_onehot;
                    rr_ptr_nxt = (arb_bin == CLIENT_ID_W'(NUM_CLIENTS-1)) ? '0
                                                                         : arb_bin + 1'b1;
                    if (in_window) begin
                        field_nxt = {{(FIELD_W-ADDR_W){1'b0}}, enc_addr};
                        bin_nxt   = arb_bin;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end
            end
            HOLD: begin
                if (egress_valid && egress_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            // One dead cycle after an error so the dropped requester can release req.
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            egress_valid     <= 1'b0;
            egress_pkt_field <= '0;
            encoded_binary   <= '0;
            client_gnt       <= '0;
            enc_err          <= 1'b0;
        end else begin
            state            <= state_nxt;
            rr_ptr           <= rr_ptr_nxt;
            egress_valid     <= valid_nxt;
            egress_pkt_field <= field_nxt;
            encoded_binary   <= bin_nxt;
            client_gnt       <= gnt_nxt;
            enc_err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ah_encoder_96_15.sv
module tb_ah_encoder_96_15;

    logic         clk = 1'b0;
    logic         rst;
    logic [14:0]  client_req;
    logic [239:0] client_offset;
    logic [14:0]  client_gnt;
    logic [95:0]  egress_pkt_field;
    logic         egress_valid;
    logic         egress_ready;
    logic [3:0]   encoded_binary;
    logic         enc_err;

    int checks  = 0;
    int errors  = 0;
    int gnt_cnt = 0;

    typedef struct {
        logic [14:0] gnt;
        logic        err;
        logic [95:0] field;
        logic [3:0]  bin;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    ah_encoder_96_15 dut (
        .clk              (clk),
        .rst              (rst),
        .client_req       (client_req),
        .client_offset    (client_offset),
        .client_gnt       (client_gnt),
        .egress_pkt_field (egress_pkt_field),
        .egress_valid     (egress_valid),
        .egress_ready     (egress_ready),
        .encoded_binary   (encoded_binary),
        .enc_err          (enc_err)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ok(input int c, input logic [31:0] field);
        exp_t e;
        e.gnt   = 15'(1) << c;
        e.err   = 1'b0;
        e.field = {64'h0, field};
        e.bin   = 4'(c);
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int c);
        exp_t e;
        e.gnt   = 15'(1) << c;
        e.err   = 1'b1;
        e.field = '0;
        e.bin   = '0;
        exp_q.push_back(e);
    endtask

    task automatic set_off(input int c, input logic [15:0] off);
        client_offset[c*16 +: 16] = off;
    endtask

    // Monitor: every grant pulse is matched against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && client_gnt != '0) begin
                gnt_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 96'(client_gnt), 96'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt", 96'(client_gnt), 96'(e.gnt));
                    check("enc_err", 96'(enc_err), 96'(e.err));
                    if (e.err) begin
                        check("err_valid", 96'(egress_valid), 96'h0);
                    end else begin
                        check("valid", 96'(egress_valid), 96'h1);
                        check("field", egress_pkt_field, e.field);
                        check("enc_bin", 96'(encoded_binary), 96'(e.bin));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        rst           = 1'b1;
        client_req    = '0;
        client_offset = '0;
        egress_ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", 96'(egress_valid), 96'h0);
        check("rst_field", egress_pkt_field, 96'h0);
        check("rst_bin",   96'(encoded_binary), 96'h0);
        check("rst_gnt",   96'(client_gnt), 96'h0);
        check("rst_err",   96'(enc_err), 96'h0);
        rst = 1'b0;
        tick();

        // 1: single request, client 3
        client_req   = 15'(1) << 3;
        set_off(3, 16'h0ABC);
        egress_ready = 1'b1;
        push_ok(3, 32'h0000_3ABC);
        tick();
        client_req = '0;
        tick();
        check("t1_valid_drop", 96'(egress_valid), 96'h0);
        tick();

        // 2: backpressure, client 1
        g0           = gnt_cnt;
        client_req   = 15'(1) << 1;
        set_off(1, 16'h0010);
        egress_ready = 1'b0;
        push_ok(1, 32'h0000_1010);
        tick();
        client_req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 96'(egress_valid), 96'h1);
            check("t2_hold_field", egress_pkt_field, 96'h1010);
            check("t2_hold_gnt",   96'(client_gnt), 96'h0);
        end
        egress_ready = 1'b1;
        tick();
        check("t2_accepted", 96'(egress_valid), 96'h0);
        check("t2_one_gnt", 96'(gnt_cnt - g0), 96'h1);
        tick();

        // 3: round-robin with wrap; reset first so priority restarts at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_off(0,  16'h0001);
        set_off(5,  16'h0234);
        set_off(14, 16'h0FFF);
        push_ok(0,  32'h0000_0001);
        push_ok(5,  32'h0000_5234);
        push_ok(14, 32'h0000_EFFF);
        push_ok(0,  32'h0000_0001);
        client_req = (15'(1) << 0) | (15'(1) << 5) | (15'(1) << 14);
        for (int i = 0; i < 7; i++) tick();
        client_req = '0;
        tick();
        tick();

        // 4: out-of-window offset; rr_ptr must move past 7 so 8 wins next
        set_off(7, 16'h1000);
        set_off(8, 16'h0020);
        push_err(7);
        push_ok(8, 32'h0000_8020);
        client_req = (15'(1) << 7) | (15'(1) << 8);
        tick();
        tick();
        check("t4_err_clear", 96'(enc_err), 96'h0);
        check("t4_gnt_clear", 96'(client_gnt), 96'h0);
        check("t4_no_valid",  96'(egress_valid), 96'h0);
        tick();
        client_req = '0;
        tick();
        tick();

        // 5: reset in HOLD discards the field; priority restarts at 0
        set_off(4, 16'h0005);
        egress_ready = 1'b0;
        push_ok(4, 32'h0000_4005);
        client_req = 15'(1) << 4;
        tick();
        client_req = '0;
        tick();
        check("t5_pending", 96'(egress_valid), 96'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 96'(egress_valid), 96'h0);
        check("t5_rst_field", egress_pkt_field, 96'h0);
        check("t5_rst_bin",   96'(encoded_binary), 96'h0);
        set_off(2, 16'h0002);
        set_off(9, 16'h0009);
        egress_ready = 1'b1;
        push_ok(2, 32'h0000_2002);
        push_ok(9, 32'h0000_9009);
        client_req = (15'(1) << 2) | (15'(1) << 9);
        tick();
        client_req = 15'(1) << 9;
        tick();
        tick();
        client_req = '0;
        tick();
        tick();
        tick();
        check("sb_drained", 96'(exp_q.size()), 96'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
